// File: rtl/laser_pkg.sv
// Shared definitions for the LASER host: run constants, FSM states and the
// packed {y,x} point format used by the point RAM and the coverage checker.
package laser_pkg;

  localparam int NPTS      = 40;
  localparam int RADIUS_SQ = 16;
  localparam int COORD_W   = 4;
  localparam int PT_W      = 2 * COORD_W;

  typedef enum logic [2:0] {
    IDLE,
    RSTDUT,
    SEND,
    WAIT,
    SCORE,
    REPORT
  } state_t;

  typedef logic [PT_W-1:0] point_t;

  function automatic point_t pack_point(input logic [COORD_W-1:0] x,
                                        input logic [COORD_W-1:0] y);
    return {y, x};
  endfunction

endpackage

// File: rtl/laser_cover_chk.sv
// Combinational test of whether one point lies within the inclusion radius
// of either of two circle centres (all in packed {y,x} format).
module laser_cover_chk
  import laser_pkg::*;
(
  input  logic [PT_W-1:0] pt,
  input  logic [PT_W-1:0] c1,
  input  logic [PT_W-1:0] c2,
  output logic            covered
);

  function automatic logic [8:0] dist_sq(input point_t a, input point_t b);
    logic signed [4:0] dx;
    logic signed [4:0] dy;
    logic signed [7:0] dxe;
    logic signed [7:0] dye;
    logic [7:0]        sx;
    logic [7:0]        sy;
    dx  = $signed({1'b0, a[COORD_W-1:0]}) - $signed({1'b0, b[COORD_W-1:0]});
    dy  = $signed({1'b0, a[PT_W-1:COORD_W]}) - $signed({1'b0, b[PT_W-1:COORD_W]});
    dxe = {{3{dx[4]}}, dx};
    dye = {{3{dy[4]}}, dy};
    // |d| <= 15, so the low 8 bits of the signed product are the exact square.
    sx  = dxe * dxe;
    sy  = dye * dye;
    return {1'b0, sx} + {1'b0, sy};
  endfunction

  logic [8:0] d1_sq;
  logic [8:0] d2_sq;

  always_comb begin
    d1_sq   = dist_sq(pt, c1);
    d2_sq   = dist_sq(pt, c2);
    covered = (d1_sq <= 9'(RADIUS_SQ)) || (d2_sq <= 9'(RADIUS_SQ));
  end

endmodule

// File: rtl/laser_host.sv
// Host side of the LASER interface: loads points, resets and feeds the
// engine, waits for DONE (with timeout) and scores the returned circles.
module laser_host
  import laser_pkg::*;
#(
  parameter int TO_W = 20
) (
  input  logic         CLK,
  input  logic         RST_N,
  input  logic         load_en,
  input  logic [5:0]   load_addr,
  input  logic [3:0]   load_x,
  input  logic [3:0]   load_y,
  input  logic         start,
  output logic         busy,
  output logic         LRST,
  output logic [3:0]   X,
  output logic [3:0]   Y,
  input  logic [3:0]   C1X,
  input  logic [3:0]   C1Y,
  input  logic [3:0]   C2X,
  input  logic [3:0]   C2Y,
  input  logic         DONE,
  output logic         res_valid,
  output logic         res_timeout,
  output logic [7:0]   res_c1,
  output logic [7:0]   res_c2,
  output logic [5:0]   res_cover
);

  point_t ram [NPTS];

  state_t          state_q, state_d;
  logic [5:0]      idx_q, idx_d;
  logic [TO_W-1:0] to_q, to_d;
  logic [TO_W-1:0] to_inc;
  logic [5:0]      acc_q, acc_d;
  point_t          c1_q, c1_d;
  point_t          c2_q, c2_d;
  logic            lrst_q, lrst_d;
  logic [3:0]      x_q, x_d;
  logic [3:0]      y_q, y_d;
  logic            busy_q, busy_d;
  logic            res_valid_q, res_valid_d;
  logic            res_timeout_q, res_timeout_d;
  point_t          res_c1_q, res_c1_d;
  point_t          res_c2_q, res_c2_d;
  logic [5:0]      res_cover_q, res_cover_d;

  point_t rd_pt;
  logic   covered;

  always_ff @(posedge CLK) begin
    if (state_q == IDLE && load_en && load_addr < 6'(NPTS)) begin
      ram[load_addr] <= pack_point(load_x, load_y);
    end
  end

  assign rd_pt = ram[idx_q];

  laser_cover_chk u_cover (
    .pt      (rd_pt),
    .c1      (c1_q),
    .c2      (c2_q),
    .covered (covered)
  );

  always_comb begin
    state_d       = state_q;
    idx_d         = idx_q;
    to_d          = to_q;
    to_inc        = to_q + 1'b1;
    acc_d         = acc_q;
    c1_d          = c1_q;
    c2_d          = c2_q;
    lrst_d        = lrst_q;
    x_d           = x_q;
    y_d           = y_q;
    busy_d        = busy_q;
    res_valid_d   = 1'b0;
    res_timeout_d = res_timeout_q;
    res_c1_d      = res_c1_q;
    res_c2_d      = res_c2_q;
    res_cover_d   = res_cover_q;

    case (state_q)
      IDLE: begin
        lrst_d = 1'b1;
        busy_d = 1'b0;
        if (start) begin
          state_d = RSTDUT;
          busy_d  = 1'b1;
          idx_d   = '0;
        end
      end

      // The X/Y register runs one index ahead so point 0 shows in the first SEND cycle.
      RSTDUT: begin
        lrst_d     = 1'b0;
        {y_d, x_d} = rd_pt;
        idx_d      = idx_q + 6'd1;
        state_d    = SEND;
      end

      SEND: begin
        if (idx_q == 6'(NPTS)) begin
          state_d = WAIT;
          to_d    = '0;
        end else begin
          {y_d, x_d} = rd_pt;
          idx_d      = idx_q + 6'd1;
        end
      end

      WAIT: begin
        to_d = to_inc;
        if (DONE) begin
          c1_d    = {C1Y, C1X};
          c2_d    = {C2Y, C2X};
          idx_d   = '0;
          acc_d   = '0;
          state_d = SCORE;
        end else if (&to_inc) begin
          res_timeout_d = 1'b1;
          res_c1_d      = '0;
          res_c2_d      = '0;
          res_cover_d   = '0;
          res_valid_d   = 1'b1;
          state_d       = REPORT;
        end
      end

      SCORE: begin
        acc_d = acc_q + {5'b0, covered};
        idx_d = idx_q + 6'd1;
        if (idx_q == 6'(NPTS - 1)) begin
          res_timeout_d = 1'b0;
          res_c1_d      = c1_q;
          res_c2_d      = c2_q;
          res_cover_d   = acc_q + {5'b0, covered};
          res_valid_d   = 1'b1;
          state_d       = REPORT;
        end
      end

      REPORT: begin
        busy_d  = 1'b0;
        lrst_d  = 1'b1;
        state_d = IDLE;
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q       <= IDLE;
      idx_q         <= '0;
      to_q          <= '0;
      acc_q         <= '0;
      c1_q          <= '0;
      c2_q          <= '0;
      lrst_q        <= 1'b1;
      x_q           <= '0;
      y_q           <= '0;
      busy_q        <= 1'b0;
      res_valid_q   <= 1'b0;
      res_timeout_q <= 1'b0;
      res_c1_q      <= '0;
      res_c2_q      <= '0;
      res_cover_q   <= '0;
    end else begin
      state_q       <= state_d;
      idx_q         <= idx_d;
      to_q          <= to_d;
      acc_q         <= acc_d;
      c1_q          <= c1_d;
      c2_q          <= c2_d;
      lrst_q        <= lrst_d;
      x_q           <= x_d;
      y_q           <= y_d;
      busy_q        <= busy_d;
      res_valid_q   <= res_valid_d;
      res_timeout_q <= res_timeout_d;
      res_c1_q      <= res_c1_d;
      res_c2_q      <= res_c2_d;
      res_cover_q   <= res_cover_d;
    end
  end

  assign busy        = busy_q;
  assign LRST        = lrst_q;
  assign X           = x_q;
  assign Y           = y_q;
  assign res_valid   = res_valid_q;
  assign res_timeout = res_timeout_q;
  assign res_c1      = res_c1_q;
  assign res_c2      = res_c2_q;
  assign res_cover   = res_cover_q;

endmodule

// File: tb/tb_laser_host.sv
// Self-checking bench for laser_host: directed and random solves checked
// against a distance-arithmetic coverage model, plus timeout and reset cases.
module tb_laser_host;
  import laser_pkg::*;

  localparam int TB_TO_W   = 4;
  localparam int TO_CYCLES = (1 << TB_TO_W) - 1;

  logic       CLK = 1'b0;
  logic       RST_N;
  logic       load_en;
  logic [5:0] load_addr;
  logic [3:0] load_x, load_y;
  logic       start;
  logic       busy, LRST;
  logic [3:0] X, Y;
  logic [3:0] C1X, C1Y, C2X, C2Y;
  logic       DONE;
  logic       res_valid, res_timeout;
  logic [7:0] res_c1, res_c2;
  logic [5:0] res_cover;

  int checks = 0;
  int errors = 0;
  int mx [NPTS];
  int my [NPTS];

  always #5 CLK = ~CLK;

  laser_host #(.TO_W(TB_TO_W)) dut (
    .CLK(CLK), .RST_N(RST_N),
    .load_en(load_en), .load_addr(load_addr), .load_x(load_x), .load_y(load_y),
    .start(start), .busy(busy), .LRST(LRST), .X(X), .Y(Y),
    .C1X(C1X), .C1Y(C1Y), .C2X(C2X), .C2Y(C2Y), .DONE(DONE),
    .res_valid(res_valid), .res_timeout(res_timeout),
    .res_c1(res_c1), .res_c2(res_c2), .res_cover(res_cover)
  );

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Coverage computed directly from Euclidean distance on integer coordinates.
  function automatic int modelCover(int ax, int ay, int bx, int by);
    int cnt = 0;
    for (int k = 0; k < NPTS; k++) begin
      if ((mx[k]-ax)*(mx[k]-ax) + (my[k]-ay)*(my[k]-ay) <= RADIUS_SQ ||
          (mx[k]-bx)*(mx[k]-bx) + (my[k]-by)*(my[k]-by) <= RADIUS_SQ)
        cnt++;
    end
    return cnt;
  endfunction

  task automatic loadPoint(input int addr, input int x, input int y);
    load_en   = 1'b1;
    load_addr = 6'(addr);
    load_x    = 4'(x);
    load_y    = 4'(y);
    @(negedge CLK);
    load_en   = 1'b0;
  endtask

  task automatic setPoint(input int k, input int x, input int y);
    mx[k] = x;
    my[k] = y;
    loadPoint(k, x, y);
  endtask

  // One full solve; doneDelay < 0 means the engine never answers.
  task automatic applyStimulus(input int doneDelay, input bit earlyDone,
                               input int c1x, input int c1y, input int c2x, input int c2y,
                               input string tag);
    int  n;
    bit  seen;
    int  expCover;
    int  expLat;
    logic [7:0] expC1, expC2;
    C1X = 4'(c1x); C1Y = 4'(c1y); C2X = 4'(c2x); C2Y = 4'(c2y);
    start = 1'b1;
    @(negedge CLK);
    start = 1'b0;
    checkOutput({tag, "_busy_rstdut"}, 32'(busy), 32'd1);
    checkOutput({tag, "_lrst_rstdut"}, 32'(LRST), 32'd1);
    @(negedge CLK);
    for (int k = 0; k < NPTS; k++) begin
      checkOutput($sformatf("%s_send%0d", tag, k), {23'd0, LRST, Y, X},
                  {23'd0, 1'b0, 4'(my[k]), 4'(mx[k])});
      DONE = earlyDone && (k == 10 || k == 0);
      @(negedge CLK);
    end
    DONE = 1'b0;
    n = 0;
    seen = 1'b0;
    while (!seen && n <= 300) begin
      DONE = (doneDelay >= 0) && (n == doneDelay);
      if (res_valid === 1'b1) seen = 1'b1;
      else begin
        @(negedge CLK);
        n++;
      end
    end
    DONE = 1'b0;
    checkOutput({tag, "_res_valid_seen"}, 32'(seen), 32'd1);
    if (doneDelay < 0) begin
      expLat = TO_CYCLES; expCover = 0; expC1 = 8'h00; expC2 = 8'h00;
    end else begin
      expLat = doneDelay + 1 + NPTS;
      expCover = modelCover(c1x, c1y, c2x, c2y);
      expC1 = {4'(c1y), 4'(c1x)};
      expC2 = {4'(c2y), 4'(c2x)};
    end
    checkOutput({tag, "_latency"}, 32'(n), 32'(expLat));
    checkOutput({tag, "_busy_report"}, 32'(busy), 32'd1);
    checkOutput({tag, "_timeout"}, 32'(res_timeout), 32'(doneDelay < 0));
    checkOutput({tag, "_c1"}, 32'(res_c1), 32'(expC1));
    checkOutput({tag, "_c2"}, 32'(res_c2), 32'(expC2));
    checkOutput({tag, "_cover"}, 32'(res_cover), 32'(expCover));
    @(negedge CLK);
    checkOutput({tag, "_valid_pulse"}, 32'(res_valid), 32'd0);
    checkOutput({tag, "_busy_idle"}, 32'(busy), 32'd0);
    checkOutput({tag, "_lrst_idle"}, 32'(LRST), 32'd1);
    checkOutput({tag, "_cover_hold"}, 32'(res_cover), 32'(expCover));
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation did not complete");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    bit sawValid;
    RST_N = 1'b0; load_en = 1'b0; load_addr = '0; load_x = '0; load_y = '0;
    start = 1'b0; DONE = 1'b0; C1X = '0; C1Y = '0; C2X = '0; C2Y = '0;
    repeat (3) @(negedge CLK);
    checkOutput("rst_lrst", 32'(LRST), 32'd1);
    checkOutput("rst_busy", 32'(busy), 32'd0);
    checkOutput("rst_valid", 32'(res_valid), 32'd0);
    checkOutput("rst_xy", 32'({Y, X}), 32'd0);
    checkOutput("rst_res", 32'({res_timeout, res_c1, res_c2, res_cover}), 32'd0);
    RST_N = 1'b1;
    @(negedge CLK);

    $display("[TB] all points at (8,8)");
    for (int k = 0; k < NPTS; k++) setPoint(k, 8, 8);
    applyStimulus(3, 1'b0, 8, 8, 0, 0, "all88");

    $display("[TB] two clusters");
    for (int k = 0; k < NPTS; k++) setPoint(k, (k < 20) ? 2 : 13, (k < 20) ? 2 : 13);
    applyStimulus(0, 1'b1, 2, 2, 13, 13, "clust_both");
    applyStimulus(5, 1'b0, 2, 2, 0, 15, "clust_one");

    $display("[TB] radius boundary");
    for (int k = 0; k < NPTS; k++) setPoint(k, 15, 0);
    setPoint(7, 6, 2);
    setPoint(21, 5, 5);
    applyStimulus(1, 1'b0, 2, 2, 15, 15, "boundary");

    $display("[TB] timeout then normal run");
    loadPoint(45, 9, 9);
    applyStimulus(-1, 1'b0, 2, 2, 15, 15, "timeout");
    applyStimulus(TO_CYCLES - 1, 1'b0, 2, 2, 15, 15, "done_at_limit");

    $display("[TB] random runs");
    for (int r = 0; r < 8; r++) begin
      for (int k = 0; k < NPTS; k++) setPoint(k, int'($urandom_range(15, 0)), int'($urandom_range(15, 0)));
      applyStimulus(int'($urandom_range(TO_CYCLES - 1, 0)), 1'b0,
                    int'($urandom_range(15, 0)), int'($urandom_range(15, 0)),
                    int'($urandom_range(15, 0)), int'($urandom_range(15, 0)),
                    $sformatf("rand%0d", r));
    end

    $display("[TB] reset during SEND");
    start = 1'b1;
    @(negedge CLK);
    start = 1'b0;
    repeat (6) @(negedge CLK);
    checkOutput("mid_lrst_send", 32'(LRST), 32'd0);
    load_en = 1'b1; load_addr = 6'd0;
    load_x = 4'(15 - mx[0]); load_y = 4'(15 - my[0]);
    @(negedge CLK);
    load_en = 1'b0;
    RST_N = 1'b0;
    #1;
    checkOutput("mid_rst_lrst", 32'(LRST), 32'd1);
    checkOutput("mid_rst_busy", 32'(busy), 32'd0);
    @(negedge CLK);
    RST_N = 1'b1;
    sawValid = 1'b0;
    repeat (120) begin
      @(negedge CLK);
      if (res_valid === 1'b1) sawValid = 1'b1;
    end
    checkOutput("mid_no_valid", 32'(sawValid), 32'd0);
    checkOutput("mid_busy_idle", 32'(busy), 32'd0);
    applyStimulus(2, 1'b0, int'($urandom_range(15, 0)), int'($urandom_range(15, 0)), 7, 7, "after_rst");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/laser_host.md
Name: laser_host

Overview:
- Host/driver end of the LASER point-coverage interface.
- Holds a 40-point set loaded by the system, resets the LASER engine, and streams the points on X/Y, one per cycle.
- Waits for DONE, captures the two circle centres, then independently scores how many points lie within radius 4 of either centre.
- Sits between the system controller and the LASER engine; owns the engine's active-high reset.

Parameters:
- NPTS, 40, points per run (fixed by the engine protocol).
- RADIUS_SQ, 16, inclusion bound on dx*dx+dy*dy.
- TO_W, 20, width of the DONE-timeout counter; timeout fires after 2**TO_W-1 wait cycles.

Ports:
- CLK  in  1  clock, all logic on rising edge.
- RST_N  in  1  asynchronous active-low reset.
- load_en  in  1  write one point into the point RAM.
- load_addr  in  6  point index 0..NPTS-1; values >= NPTS are ignored.
- load_x  in  4  point x.
- load_y  in  4  point y.
- start  in  1  single-cycle request to run one solve.
- busy  out  1  high from start acceptance to the res_valid cycle inclusive.
- LRST  out  1  active-high reset to the LASER engine.
- X  out  4  point x to the engine.
- Y  out  4  point y to the engine.
- C1X, C1Y, C2X, C2Y  in  4 each  centres from the engine.
- DONE  in  1  engine result strobe.
- res_valid  out  1  one-cycle result pulse.
- res_timeout  out  1  DONE never arrived.
- res_c1  out  8  {C1Y,C1X} captured.
- res_c2  out  8  {C2Y,C2X} captured.
- res_cover  out  6  count of points covered by either circle, 0..40.

Behaviour:
- Async reset (RST_N low):
  - state=IDLE, LRST=1, X=Y=0, busy=0, res_valid=0, res_timeout=0, res_c1=res_c2=0, res_cover=0, all counters 0.
  - Point RAM contents are not reset.
- Point RAM: NPTS x 8 bits. Written on load_en in IDLE only; load_en in any other state is dropped.
- FSM states: IDLE, RSTDUT, SEND, WAIT, SCORE, REPORT.
- IDLE:
  - LRST=1.
  - start -> RSTDUT, busy=1.
  - start outside IDLE is ignored.
- RSTDUT: one cycle, LRST=1, idx=0 -> SEND.
- SEND:
  - LRST=0.
  - X/Y = point[idx] registered, so point 0 appears in the first SEND cycle.
  - idx increments each cycle; after the idx=NPTS-1 cycle -> WAIT.
  - Exactly NPTS cycles.
- WAIT:
  - X/Y hold point[NPTS-1]; the engine may sample one extra duplicate, which is harmless.
  - Timeout counter increments each cycle.
  - DONE=1 -> capture C1X..C2Y into res_c1/res_c2, -> SCORE.
  - Counter reaches all-ones with no DONE -> res_timeout=1, res_c1=res_c2=0, res_cover=0, -> REPORT.
  - DONE on the same cycle as counter all-ones: DONE wins.
  - DONE seen in RSTDUT or SEND is ignored.
- SCORE:
  - One point per cycle, idx 0..NPTS-1, so NPTS cycles.
  - Per point: dx = signed 5-bit (px - cx); square is 8 bits; sum of two squares is 9 bits.
  - Point is covered if d1sq <= RADIUS_SQ or d2sq <= RADIUS_SQ; a point inside both circles counts once.
  - Accumulator is 6 bits, cleared on SCORE entry.
  - After the last point -> REPORT.
- REPORT:
  - res_valid=1 for one cycle; busy=1 this cycle.
  - Next: IDLE, busy=0, LRST=1.
  - res_* hold their values until the next REPORT.
- Latency start -> res_valid = 1 + NPTS + (cycles waiting for DONE) + NPTS + 1, counting the WAIT entry cycle.
- Reset mid-run: returns to IDLE immediately, LRST=1, no res_valid.

Decomposition:
- Shared package laser_pkg:
  - state enum.
  - NPTS, RADIUS_SQ, coordinate width 4.
  - function or constant for the packed {y,x} point format.
- One sub-module, laser_cover_chk (combinational): inputs point, c1, c2; output covered bit.
  - Reusable by the verification scoreboard.

Test Plan:
- Load 40 points all at (8,8); start; engine model returns C1=(8,8), C2=(0,0) -> res_cover=40, res_timeout=0, res_c1=8'h88.
- Points 0..19 at (2,2), 20..39 at (13,13); centres (2,2),(13,13) -> res_cover=40. Swap C2 to (0,15) -> res_cover=20.
- Boundary point (6,2) with C1=(2,2): d²=16 -> covered. Point (5,5) with C1=(2,2): d²=18 -> not covered. Other 38 points far -> res_cover=1.
- Check X/Y sequence in SEND equals RAM order 0..39 on 40 consecutive cycles, with LRST low starting the first SEND cycle and high for exactly the one RSTDUT cycle before it.
- DONE never asserted, TO_W=4 -> res_valid after 15 WAIT cycles with res_timeout=1, res_cover=0. A second start then runs normally.
- RST_N pulsed low during SEND -> LRST=1, busy=0 next cycle, no res_valid. load_en during SEND does not alter the RAM.
